fifo_wr_arb: RTL
================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter WORD_WIDTH, default 33, SHALL set the width of every data path in the block.
REQ-002 Parameter MAX_BURST, default 8, SHALL set the maximum number of words accepted per grant (range 2..16).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req0  input  1  requester 0 has a word on data0.
REQ-006 data0  input  WORD_WIDTH  requester 0 write word.
REQ-007 last0  input  1  data0 is the final word of requester 0's packet.
REQ-008 ack0  output  1  data0 accepted into the FIFO this cycle.
REQ-009 req1, data1, last1, ack1 SHALL be identical in direction, width and meaning, for requester 1.
REQ-010 fifo_full  input  1  full flag from the shared FIFO.
REQ-011 fifo_wr  output  1  write strobe to the shared FIFO.
REQ-012 fifo_wr_data  output  WORD_WIDTH  write word to the shared FIFO.
REQ-013 owner  output  1  index of the granted requester; valid only while busy=1.
REQ-014 busy  output  1  a grant is currently held.

Function
REQ-015 The block SHALL implement the FSM states IDLE, GNT0 and GNT1, plus a 1-bit priority pointer prio and a burst counter cnt of width ceil(log2(MAX_BURST)).
REQ-016 In IDLE with only reqN=1, the FSM SHALL move to GNTN on the next edge; with both requests, it SHALL move to GNT(prio); with no request, it SHALL stay in IDLE.
REQ-017 Arbitration latency SHALL be exactly one cycle: no word is accepted in the cycle the FSM is in IDLE.
REQ-018 In GNTN, accept SHALL equal reqN & ~fifo_full; fifo_wr and ackN SHALL both equal accept (combinational), and ack of the other requester SHALL be 0.
REQ-019 fifo_wr_data SHALL equal dataN in GNTN and all-zeros in IDLE.
REQ-020 On each accept, cnt SHALL increment; while fifo_full=1, cnt, state and grant SHALL hold.
REQ-021 A grant SHALL release at the edge that ends an accept cycle in which either lastN=1 or cnt=MAX_BURST-1 (the MAX_BURST-th word).
REQ-022 A grant SHALL also release at the edge where reqN=0 in GNTN (abandoned burst); no word is written in that cycle.
REQ-023 On any release from GNTN: prio SHALL become 1-N; cnt SHALL clear to 0; the next state SHALL be GNT(1-N) if req(1-N)=1 in the release cycle, otherwise IDLE.
REQ-024 A handover under REQ-023 SHALL insert no idle cycle, so back-to-back bursts from alternating requesters reach full FIFO bandwidth.
REQ-025 A release to IDLE followed by a lone re-request from the same requester SHALL be granted normally; prio only breaks ties.
REQ-026 busy SHALL be 1 in GNT0/GNT1 and 0 in IDLE; owner SHALL be 1 only in GNT1.
REQ-027 The block SHALL never assert fifo_wr while fifo_full=1, and SHALL never assert ack0 and ack1 in the same cycle.

Reset
REQ-028 When rst=1 at a clock edge: state SHALL become IDLE, prio 0, cnt 0; consequently fifo_wr, ack0, ack1, busy and owner SHALL be 0 and fifo_wr_data all-zeros from that edge.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no further write and SHALL take priority over every other input.

Verification
REQ-030 Both requests asserted from reset, lastN=0 held -> GNT0 granted; exactly 8 writes of data0; then handover to GNT1 with no gap; 8 writes of data1; then back to GNT0.
REQ-031 Only req0, 3-word packet with last0 on word 3 -> 3 acks, then IDLE, busy=0, prio=1.
REQ-032 GNT1 mid-burst, fifo_full=1 for 4 cycles -> fifo_wr=0, ack1=0, cnt and owner held; writes resume the cycle after fifo_full drops and the total count stays at 8.
REQ-033 req0 drops after 2 accepted words with last0=0 -> release to GNT1 if req1=1, else IDLE; cnt=0.
REQ-034 rst pulsed during the 5th word of a GNT0 burst -> the next cycle shows IDLE, all outputs 0, prio=0; a subsequent tie is granted to requester 0.
REQ-035 Random traffic with a FIFO model -> no write while full, no simultaneous acks, no burst over MAX_BURST words, and the written word sequence equals the acked word sequence.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Two-requester write arbiter for a shared FIFO: burst grants of up to MAX_BURST words,
// round-robin tie breaking, and zero-gap handover between requesters.
module fifo_wr_arb #(
    parameter int WORD_WIDTH = 33,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [WORD_WIDTH-1:0] data0,
    input  logic                  last0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [WORD_WIDTH-1:0] data1,
    input  logic                  last1,
    output logic                  ack1,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [WORD_WIDTH-1:0] fifo_wr_data,
    output logic                  owner,
    output logic                  busy
);

    localparam int CW = $clog2(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state_q;
    logic            prio_q;
    logic [CW-1:0]   cnt_q;

    logic            in_gnt;
    logic            gnt_req;
    logic            gnt_last;
    logic            other_req;
    logic            accept;
    logic            release_gnt;

    always_comb begin
        in_gnt    = (state_q == GNT0) || (state_q == GNT1);
        gnt_req   = (state_q == GNT1) ? req1  : req0;
        gnt_last  = (state_q == GNT1) ? last1 : last0;
        other_req = (state_q == GNT1) ? req0  : req1;
        accept    = in_gnt && gnt_req && !fifo_full;
        // A dropped request ends the burst as well as last or the MAX_BURST-th word.
        release_gnt = in_gnt && (!gnt_req || (accept && (gnt_last || cnt_q == CNT_LAST)));
    end

    assign ack0    = accept && (state_q == GNT0);
    assign ack1    = accept && (state_q == GNT1);
    assign fifo_wr = accept;
    assign busy    = in_gnt;
    assign owner   = (state_q == GNT1);

    always_comb begin
        fifo_wr_data = '0;
        if (state_q == GNT0) begin
            fifo_wr_data = data0;
        end else if (state_q == GNT1) begin
            fifo_wr_data = data1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 && req1) begin
                        state_q <= prio_q ? GNT1 : GNT0;
                    end else if (req0) begin
                        state_q <= GNT0;
                    end else if (req1) begin
                        state_q <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (release_gnt) begin
                        prio_q <= (state_q == GNT0);
                        cnt_q  <= '0;
                        if (other_req) begin
                            state_q <= (state_q == GNT0) ? GNT1 : GNT0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (accept) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
